// File: rtl/fir_sched_pkg.sv
// Shared types and arithmetic helpers for the FIR MAC scheduler and the FIR filters.
package fir_sched_pkg;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   localparam int QBITS_DEF = 10;
   localparam int DEQ_W     = 64;   // widest sample/coefficient supported by dequantize

   // Requester index as carried between channel filters and output FIFOs.
   typedef logic [7:0] req_id_t;

   // Arithmetic shift that rounds toward zero instead of toward -inf.
   function automatic logic signed [DEQ_W-1:0] dequantize(input logic signed [DEQ_W-1:0] v,
                                                          input int unsigned            q);
      if (!v[DEQ_W-1]) return v >>> q;
      else             return -((-v) >>> q);
   endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Requester/consumer bus of the FIR MAC scheduler.
interface fir_mac_scheduler_if #(
   parameter int N_REQ     = 2,
   parameter int TAPS      = 32,
   parameter int DATA_SIZE = 32
);
   localparam int TAP_W = $clog2(TAPS);
   localparam int ID_W  = $clog2(N_REQ);

   logic [N_REQ-1:0]                req;
   logic [N_REQ-1:0]                grant;
   logic [TAP_W-1:0]                tap_idx;
   logic [N_REQ-1:0][DATA_SIZE-1:0] x_data;
   logic [N_REQ-1:0][DATA_SIZE-1:0] c_data;
   logic [DATA_SIZE-1:0]            res_data;
   logic [ID_W-1:0]                 res_id;
   logic                            res_valid;
   logic                            res_ready;

   // master: the scheduler; slave: the channel filters and output FIFO
   modport master (input  req, x_data, c_data, res_ready,
                   output grant, tap_idx, res_data, res_id, res_valid);
   modport slave  (output req, x_data, c_data, res_ready,
                   input  grant, tap_idx, res_data, res_id, res_valid);
endinterface

// File: rtl/fir_mac_unit.sv
// Two-stage multiply / dequantize / accumulate datapath shared by all requesters.
module fir_mac_unit
   import fir_sched_pkg::*;
#(
   parameter int          DATA_SIZE = 32,
   parameter int unsigned QBITS     = QBITS_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 last,
   input  logic [DATA_SIZE-1:0] x,
   input  logic [DATA_SIZE-1:0] c,
   output logic [DATA_SIZE-1:0] acc
);
   logic [DATA_SIZE-1:0] prod;
   logic [DATA_SIZE-1:0] prod_t;
   logic [DATA_SIZE-1:0] deq;

   // Low half of the product is identical for signed and unsigned operands.
   assign prod_t = c * x;
   assign deq    = DATA_SIZE'(dequantize(DEQ_W'($signed(prod_t)), QBITS));

   // prod is cleared with acc, so the first MAC cycle adds zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prod <= '0;
         acc  <= '0;
      end else if (clear) begin
         prod <= '0;
         acc  <= '0;
      end else begin
         if (en)         prod <= deq;
         if (en || last) acc  <= acc + prod;
      end
   end
endmodule

// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler time-sharing one MAC datapath between N_REQ FIR requesters.
module fir_mac_scheduler
   import fir_sched_pkg::*;
#(
   parameter int          N_REQ     = 2,
   parameter int          TAPS      = 32,
   parameter int          DATA_SIZE = 32,
   parameter int unsigned QBITS     = QBITS_DEF,
   parameter int          TAP_W     = $clog2(TAPS),
   parameter int          ID_W      = $clog2(N_REQ)
) (
   input  logic                clock,
   input  logic                reset,
   fir_mac_scheduler_if.master bus,
   output logic                busy
);
   state_t                          state;
   logic [ID_W-1:0]                 last_id;
   logic [ID_W-1:0]                 gid;
   logic [ID_W-1:0]                 pick;
   logic [ID_W-1:0]                 pick_hi;
   logic [ID_W-1:0]                 pick_lo;
   logic                            hit_hi;
   logic [N_REQ-1:0][DATA_SIZE-1:0] x_m;
   logic [N_REQ-1:0][DATA_SIZE-1:0] c_m;
   logic [DATA_SIZE-1:0]            x_sel;
   logic [DATA_SIZE-1:0]            c_sel;
   logic [DATA_SIZE-1:0]            acc;
   logic                            start;

   // Round robin: lowest requester above last_id, else lowest overall.
   always_comb begin
      pick_hi = '0;
      pick_lo = '0;
      hit_hi  = 1'b0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (bus.req[i] && (ID_W'(i) > last_id)) begin
            pick_hi = ID_W'(i);
            hit_hi  = 1'b1;
         end
         if (bus.req[i]) pick_lo = ID_W'(i);
      end
      pick = hit_hi ? pick_hi : pick_lo;
   end

   // AND-OR operand mux keyed by the one-hot grant keeps X on idle lanes out.
   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign x_m[i] = bus.x_data[i] & {DATA_SIZE{bus.grant[i]}};
      assign c_m[i] = bus.c_data[i] & {DATA_SIZE{bus.grant[i]}};
   end

   always_comb begin
      x_sel = '0;
      c_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         x_sel = x_sel | x_m[i];
         c_sel = c_sel | c_m[i];
      end
   end

   assign start = (state == IDLE) && (|bus.req);

   fir_mac_unit #(.DATA_SIZE(DATA_SIZE), .QBITS(QBITS)) u_mac (
      .clock (clock),
      .reset (reset),
      .clear (start),
      .en    (state == MAC),
      .last  (state == DRAIN),
      .x     (x_sel),
      .c     (c_sel),
      .acc   (acc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bus.grant     <= '0;
         bus.tap_idx   <= '0;
         bus.res_data  <= '0;
         bus.res_id    <= '0;
         bus.res_valid <= 1'b0;
         busy          <= 1'b0;
         gid           <= '0;
         last_id       <= ID_W'(N_REQ-1);
      end else begin
         case (state)
            IDLE: if (start) begin
               bus.grant   <= N_REQ'(1) << pick;
               gid         <= pick;
               bus.tap_idx <= '0;
               busy        <= 1'b1;
               state       <= MAC;
            end
            MAC: begin
               if (bus.tap_idx == TAP_W'(TAPS-1)) begin
                  bus.tap_idx <= '0;
                  state       <= DRAIN;
               end else begin
                  bus.tap_idx <= bus.tap_idx + TAP_W'(1);
               end
            end
            DRAIN: state <= OUT;
            OUT: begin
               // First OUT cycle latches the settled accumulator.
               if (!bus.res_valid) begin
                  bus.res_data  <= acc;
                  bus.res_id    <= gid;
                  bus.res_valid <= 1'b1;
               end else if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  bus.grant     <= '0;
                  last_id       <= gid;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
